// File: rtl/inst_queue_fd.sv
// inst_queue_fd: circular FIFO between fetch and decode.
// Holds {adel, pc, inst} packets from fetch. It presents the oldest packet to
// decode and discards every buffered packet when a pipeline flush occurs.
module inst_queue_fd #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs_valid,
  input  logic [31:0]      fs_pc,
  input  logic [31:0]      fs_inst,
  input  logic             fs_adel,
  output logic             fs_allowin,
  input  logic             de_allowin,
  output logic             de_valid,
  output logic [31:0]      pc_de,
  output logic [31:0]      inst_de,
  output logic             adel_de,
  input  logic             flush,
  output logic [CNT_W-1:0] q_count
);

  localparam int ENTRY_W = 65;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] head;

  // Handshake qualification. A flush suppresses both sides in the same cycle.
  // The queue is never full with a bypass, so a full queue refuses fetch even while decode pops.
  assign fs_allowin = (cnt_q != CNT_W'(DEPTH));
  assign de_valid   = (cnt_q != '0);
  assign push       = fs_valid & fs_allowin & ~flush;
  assign pop        = de_valid & de_allowin & ~flush;
  assign q_count    = cnt_q;

  // Head presentation: the outputs are forced to zero while the queue is empty,
  // so decode never sees data left over in a drained slot.
  assign head    = mem_q[rd_ptr_q];
  assign adel_de = de_valid ? head[64]    : 1'b0;
  assign pc_de   = de_valid ? head[63:32] : 32'h0;
  assign inst_de = de_valid ? head[31:0]  : 32'h0;

  // Next-state pointers and occupancy. The flush case takes priority over push and pop.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage: the tail slot is written on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Entries are only observable while cnt_q covers them.
    if (push) mem_q[wr_ptr_q] <= {fs_adel, fs_pc, fs_inst};
  end

  // Consistency check: pointer distance matches occupancy, and occupancy never exceeds DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (PTR_W'(wr_ptr_q - rd_ptr_q) == cnt_q[PTR_W-1:0])
        else $error("inst_queue_fd pointer/count inconsistency");
      assert (cnt_q <= CNT_W'(DEPTH))
        else $error("inst_queue_fd occupancy above DEPTH");
    end
  end

endmodule

// File: tb/tb_inst_queue_fd.sv
// tb_inst_queue_fd: directed self-checking bench for inst_queue_fd.
module tb_inst_queue_fd;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_valid, fs_adel, de_allowin, flush;
  logic [31:0] fs_pc, fs_inst;
  logic        fs_allowin, de_valid, adel_de;
  logic [31:0] pc_de, inst_de;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  inst_queue_fd #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .fs_valid   (fs_valid),
    .fs_pc      (fs_pc),
    .fs_inst    (fs_inst),
    .fs_adel    (fs_adel),
    .fs_allowin (fs_allowin),
    .de_allowin (de_allowin),
    .de_valid   (de_valid),
    .pc_de      (pc_de),
    .inst_de    (inst_de),
    .adel_de    (adel_de),
    .flush      (flush),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [31:0] pc, input logic adel);
    fs_valid = 1'b1;
    fs_pc    = pc;
    fs_inst  = ~pc;
    fs_adel  = adel;
  endtask

  task automatic idle_fetch();
    fs_valid = 1'b0;
    fs_adel  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fs_valid = 1'b0; fs_pc = '0; fs_inst = '0; fs_adel = 1'b0;
    de_allowin = 1'b0; flush = 1'b0;
    #2;
    check("rst_de_valid", 32'(de_valid), 32'd0);
    check("rst_allowin",  32'(fs_allowin), 32'd1);
    check("rst_count",    32'(q_count), 32'd0);
    check("rst_pc",       pc_de, 32'h0);
    #1 rst = 1'b0;

    // 1: a single packet appears at the head one cycle after the push.
    drive_pkt(32'hBFC0_0000, 1'b0);
    fs_inst = 32'h3C1D_8000;
    tick();
    idle_fetch();
    check("t1_valid", 32'(de_valid), 32'd1);
    check("t1_pc",    pc_de, 32'hBFC0_0000);
    check("t1_inst",  inst_de, 32'h3C1D_8000);
    check("t1_count", 32'(q_count), 32'd1);
    de_allowin = 1'b1;
    tick();
    de_allowin = 1'b0;
    check("t1_drained_valid", 32'(de_valid), 32'd0);
    check("t1_drained_pc",    pc_de, 32'h0);

    // 2: fill to full, confirm an extra push is refused, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive_pkt(32'h100 + 32'(4 * i), 1'b0);
      tick();
    end
    check("t2_full_count", 32'(q_count), 32'd4);
    check("t2_full_allow", 32'(fs_allowin), 32'd0);
    drive_pkt(32'h110, 1'b0);
    tick();
    idle_fetch();
    check("t2_fifth_ignored", 32'(q_count), 32'd4);
    de_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain_pc%0d", i), pc_de, 32'h100 + 32'(4 * i));
      check($sformatf("t2_drain_inst%0d", i), inst_de, ~(32'h100 + 32'(4 * i)));
      tick();
    end
    de_allowin = 1'b0;
    check("t2_empty", 32'(de_valid), 32'd0);

    // 3: steady stream with simultaneous push and pop across pointer wrap.
    de_allowin = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_pkt(32'h300 + 32'(4 * k), 1'b0);
      if (k > 0) check($sformatf("t3_pc%0d", k - 1), pc_de, 32'h300 + 32'(4 * (k - 1)));
      tick();
      check($sformatf("t3_count%0d", k), 32'(q_count), 32'd1);
    end
    idle_fetch();
    check("t3_last_pc", pc_de, 32'h324);
    tick();
    de_allowin = 1'b0;
    check("t3_empty", 32'(de_valid), 32'd0);

    // 4: a flush with both handshakes active drops all entries and the same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive_pkt(32'h400 + 32'(4 * i), 1'b0);
      tick();
    end
    check("t4_pre_count", 32'(q_count), 32'd3);
    drive_pkt(32'h40C, 1'b0);
    de_allowin = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    de_allowin = 1'b0;
    idle_fetch();
    check("t4_flush_count", 32'(q_count), 32'd0);
    check("t4_flush_valid", 32'(de_valid), 32'd0);
    check("t4_flush_allow", 32'(fs_allowin), 32'd1);
    drive_pkt(32'h200, 1'b0);
    tick();
    idle_fetch();
    check("t4_after_pc",    pc_de, 32'h200);
    check("t4_after_count", 32'(q_count), 32'd1);
    de_allowin = 1'b1;
    tick();
    de_allowin = 1'b0;
    check("t4_drained", 32'(q_count), 32'd0);

    // 5: the fetch exception flag travels with its packet only.
    drive_pkt(32'h0000_0003, 1'b1);
    tick();
    drive_pkt(32'h500, 1'b0);
    tick();
    idle_fetch();
    check("t5_adel",  32'(adel_de), 32'd1);
    check("t5_pc",    pc_de, 32'h3);
    check("t5_count", 32'(q_count), 32'd2);
    de_allowin = 1'b1;
    tick();
    check("t5_next_adel", 32'(adel_de), 32'd0);
    check("t5_next_pc",   pc_de, 32'h500);
    tick();
    de_allowin = 1'b0;
    check("t5_empty", 32'(de_valid), 32'd0);

    // 6: an asynchronous reset between edges clears the outputs immediately.
    drive_pkt(32'h600, 1'b0);
    tick();
    drive_pkt(32'h604, 1'b0);
    tick();
    idle_fetch();
    check("t6_pre_count", 32'(q_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(de_valid), 32'd0);
    check("t6_rst_count", 32'(q_count), 32'd0);
    check("t6_rst_pc",    pc_de, 32'h0);
    check("t6_rst_inst",  inst_de, 32'h0);
    check("t6_rst_allow", 32'(fs_allowin), 32'd1);
    #1 rst = 1'b0;
    drive_pkt(32'h700, 1'b0);
    tick();
    idle_fetch();
    check("t6_post_pc",    pc_de, 32'h700);
    check("t6_post_count", 32'(q_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
